// File: rtl/cdc_pulse_feeder.sv
// Source-domain feeder for the pulse/data CDC bridge: buffers ready/valid words and issues them
// as single-cycle pulses gated by the bridge's active flag. Optional watchdog: CDC_FEEDER_WATCHDOG_EN.
module cdc_pulse_feeder #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int TO_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            in_data,
  input  logic                     in_vld,
  output logic                     in_rdy,
  output logic [DW-1:0]            out_din,
  output logic                     out_vld,
  input  logic                     br_active,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     to_err
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 || TO_W < 2) begin : g_bad_param
    $error("cdc_pulse_feeder: DEPTH must be a power of two in 2..256 and TO_W >= 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GUARD = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   wr_nxt, rd_nxt;
  logic          full, empty, push, pop;

  // Pointers carry one extra bit so full and empty are distinguishable at equal addresses.
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty  = (wr_ptr == rd_ptr);
  assign in_rdy = !full;
  assign push   = in_vld && !full;
  assign pop    = (state == IDLE) && !empty && !br_active;
  assign wr_nxt = wr_ptr + {{AW{1'b0}}, push};
  assign rd_nxt = rd_ptr + {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      out_din <= '0;
      out_vld <= 1'b0;
    end else begin
      wr_ptr  <= wr_nxt;
      rd_ptr  <= rd_nxt;
      level   <= wr_nxt - rd_nxt;
      out_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            out_din <= mem[rd_ptr[AW-1:0]];
            out_vld <= 1'b1;
            state   <= SEND;
          end
        end
        SEND:  state <= GUARD;
        // The bridge raises active one cycle late, so it is only trusted from WAIT onward.
        GUARD: state <= WAIT;
        WAIT:  if (!br_active) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CDC_FEEDER_WATCHDOG_EN
  localparam logic [TO_W-1:0] WD_ONE = 1;
  localparam logic [TO_W-1:0] WD_PRE = ~WD_ONE;

  logic [TO_W-1:0] wd_cnt;
  logic            to_err_q;

  // Error is flagged on the edge the counter reaches all-ones; the transfer is never aborted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt   <= '0;
      to_err_q <= 1'b0;
    end else if (state == WAIT && br_active) begin
      if (wd_cnt != '1) wd_cnt <= wd_cnt + WD_ONE;
      if (wd_cnt == WD_PRE || wd_cnt == '1) to_err_q <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

  assign to_err = to_err_q;
`else
  assign to_err = 1'b0;
`endif

endmodule
